// File: rtl/cnn_pkg.sv
`default_nettype none
// ============================================================================
// Module   : cnn_pkg
// Purpose  : Shared sizes and FSM encoding for the classifier output stage.
// Revision : 1.0 - initial release
// ============================================================================
package cnn_pkg;

    localparam int NUM_CLASSES = 10;
    localparam int LOGIT_W     = 32;
    localparam int CLS_W       = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } argmax_state_t;

endpackage
`default_nettype wire

// File: rtl/logit_argmax_if.sv
`default_nettype none
// ============================================================================
// Module   : logit_argmax_if
// Purpose  : Logit beat input and prediction handshake bundle.
// Revision : 1.0 - initial release
// ============================================================================
interface logit_argmax_if #(
    parameter int LOGIT_W = 32
);
    logic                      in_valid;
    logic [3:0]                in_cls;
    logic signed [LOGIT_W-1:0] in_logit;
    logic                      in_last;
    logic                      pred_valid;
    logic                      pred_ready;
    logic [3:0]                pred_cls;
    logic signed [LOGIT_W-1:0] pred_logit;
    logic [LOGIT_W:0]          pred_margin;
    logic                      frame_err;
    logic                      overrun;

    modport master (
        output in_valid, in_cls, in_logit, in_last, pred_ready,
        input  pred_valid, pred_cls, pred_logit, pred_margin, frame_err, overrun
    );

    modport slave (
        input  in_valid, in_cls, in_logit, in_last, pred_ready,
        output pred_valid, pred_cls, pred_logit, pred_margin, frame_err, overrun
    );
endinterface
`default_nettype wire

// File: rtl/top2_tracker.sv
`default_nettype none
// ============================================================================
// Module   : top2_tracker
// Purpose  : Running max / second-max / argmax over the beats of one frame.
// Revision : 1.0 - initial release
// ============================================================================
module top2_tracker #(
    parameter int LOGIT_W = 32,
    parameter int CLS_W   = 4
) (
    input  wire logic                      clk,
    input  wire logic                      rst_n,
    input  wire logic                      load,
    input  wire logic                      update,
    input  wire logic                      first,
    input  wire logic signed [LOGIT_W-1:0] logit,
    input  wire logic [CLS_W-1:0]          cls,
    output logic signed [LOGIT_W-1:0]      nxt_max,
    output logic signed [LOGIT_W-1:0]      nxt_second,
    output logic [CLS_W-1:0]               nxt_cls
);

    logic signed [LOGIT_W-1:0] r_max;
    logic signed [LOGIT_W-1:0] r_second;
    logic [CLS_W-1:0]          r_cls;

    // Next values are exported so the final beat of a frame can be folded in
    // the same cycle it arrives. Beat 1 always replaces the second-max seeded
    // at load.
    always_comb begin
        nxt_max    = r_max;
        nxt_second = r_second;
        nxt_cls    = r_cls;
        if (load) begin
            nxt_max    = logit;
            nxt_second = logit;
            nxt_cls    = '0;
        end else if (update) begin
            if (logit > r_max) begin
                nxt_second = r_max;
                nxt_max    = logit;
                nxt_cls    = cls;
            end else if ((logit > r_second) || first) begin
                nxt_second = logit;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_max    <= '0;
            r_second <= '0;
            r_cls    <= '0;
        end else if (load || update) begin
            r_max    <= nxt_max;
            r_second <= nxt_second;
            r_cls    <= nxt_cls;
        end
    end

endmodule
`default_nettype wire

// File: rtl/logit_argmax.sv
`default_nettype none
// ============================================================================
// Module   : logit_argmax
// Purpose  : Frame checker, argmax result register and prediction handshake.
// Revision : 1.0 - initial release
// ============================================================================
module logit_argmax
    import cnn_pkg::*;
#(
    parameter int NUM_CLASSES = cnn_pkg::NUM_CLASSES,
    parameter int LOGIT_W     = cnn_pkg::LOGIT_W
) (
    input  wire logic   clk,
    input  wire logic   rst_n,
    logit_argmax_if.slave bus
);

    localparam logic [CLS_W-1:0] c_LAST_CLS = CLS_W'(NUM_CLASSES - 1);
    localparam logic [CLS_W:0]   c_NUM_CLS  = (CLS_W+1)'(NUM_CLASSES);

    argmax_state_t             r_state;
    logic [CLS_W-1:0]          r_exp_cnt;
    logic                      r_pred_valid;
    logic [CLS_W-1:0]          r_pred_cls;
    logic signed [LOGIT_W-1:0] r_pred_logit;
    logic [LOGIT_W:0]          r_pred_margin;
    logic                      r_frame_err;
    logic                      r_overrun;

    logic                      w_is_last_cls;
    logic                      w_bad_beat;
    logic                      w_load;
    logic                      w_update;
    logic                      w_complete;
    logic                      w_err;
    logic signed [LOGIT_W-1:0] w_nxt_max;
    logic signed [LOGIT_W-1:0] w_nxt_second;
    logic [CLS_W-1:0]          w_nxt_cls;
    logic [LOGIT_W:0]          w_margin;

    // A beat is malformed if out of order, out of range, or its in_last does
    // not coincide exactly with the final class index.
    always_comb begin
        w_is_last_cls = (bus.in_cls == c_LAST_CLS);
        w_bad_beat    = (bus.in_cls != r_exp_cnt)
                     || ({1'b0, bus.in_cls} >= c_NUM_CLS)
                     || (bus.in_last != w_is_last_cls);
        w_load     = 1'b0;
        w_update   = 1'b0;
        w_complete = 1'b0;
        w_err      = 1'b0;
        if (bus.in_valid) begin
            case (r_state)
                ST_IDLE: begin
                    if (w_bad_beat) w_err  = 1'b1;
                    else            w_load = 1'b1;
                end
                ST_RUN: begin
                    if (w_bad_beat) begin
                        w_err = 1'b1;
                    end else begin
                        w_update   = 1'b1;
                        w_complete = bus.in_last;
                    end
                end
                default: ;
            endcase
        end
    end

    top2_tracker #(
        .LOGIT_W (LOGIT_W),
        .CLS_W   (CLS_W)
    ) u_top2 (
        .clk        (clk),
        .rst_n      (rst_n),
        .load       (w_load),
        .update     (w_update),
        .first      (r_exp_cnt == CLS_W'(1)),
        .logit      (bus.in_logit),
        .cls        (bus.in_cls),
        .nxt_max    (w_nxt_max),
        .nxt_second (w_nxt_second),
        .nxt_cls    (w_nxt_cls)
    );

    assign w_margin = {w_nxt_max[LOGIT_W-1], w_nxt_max}
                    - {w_nxt_second[LOGIT_W-1], w_nxt_second};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= ST_IDLE;
            r_exp_cnt     <= '0;
            r_pred_valid  <= 1'b0;
            r_pred_cls    <= '0;
            r_pred_logit  <= '0;
            r_pred_margin <= '0;
            r_frame_err   <= 1'b0;
            r_overrun     <= 1'b0;
        end else begin
            r_frame_err <= w_err;

            if (w_err) begin
                r_exp_cnt <= '0;
                r_state   <= bus.in_last ? ST_IDLE : ST_DRAIN;
            end else if (w_load) begin
                r_exp_cnt <= CLS_W'(1);
                r_state   <= ST_RUN;
            end else if (w_complete) begin
                r_exp_cnt <= '0;
                r_state   <= ST_IDLE;
            end else if (w_update) begin
                r_exp_cnt <= r_exp_cnt + CLS_W'(1);
            end else if (r_state == ST_DRAIN && bus.in_valid && bus.in_last) begin
                r_state <= ST_IDLE;
            end

            // A completing frame wins over acceptance of the pending result.
            if (w_complete) begin
                r_pred_valid  <= 1'b1;
                r_pred_cls    <= w_nxt_cls;
                r_pred_logit  <= w_nxt_max;
                r_pred_margin <= w_margin;
                if (r_pred_valid && !bus.pred_ready) r_overrun <= 1'b1;
            end else if (r_pred_valid && bus.pred_ready) begin
                r_pred_valid <= 1'b0;
            end
        end
    end

    assign bus.pred_valid  = r_pred_valid;
    assign bus.pred_cls    = r_pred_cls;
    assign bus.pred_logit  = r_pred_logit;
    assign bus.pred_margin = r_pred_margin;
    assign bus.frame_err   = r_frame_err;
    assign bus.overrun     = r_overrun;

endmodule
`default_nettype wire
